// File: rtl/sha3_scanner_pkg.sv
// Shared types for the SHA3 nonce scanner: nonce type, candidate record,
// and the evaluator FSM state encodings.
package sha3_scanner_pkg;

  typedef logic [31:0] nonce_t;

  typedef struct packed {
    nonce_t      nonce;
    logic [63:0] hash;
  } candidate_t;

  // Evaluator FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // A hash qualifies when lane 0 of the final state is at or below target.
  function automatic logic hash_qualifies(input logic [63:0] hash, input logic [63:0] target);
    return hash <= target;
  endfunction

endpackage

// File: rtl/sha3_result_fifo.sv
// Candidate store: synchronous first-word-fall-through FIFO built as a
// shift register so the head entry and valid come straight from flops.
// A push into a full FIFO is dropped unless a pop happens the same cycle.
module sha3_result_fifo
  import sha3_scanner_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  candidate_t push_data_i,
  input  logic       pop_i,
  output logic       valid_o,
  output candidate_t data_o,
  output logic       drop_o
);

  localparam int CW = $clog2(DEPTH + 1);

  candidate_t      mem_q [DEPTH];
  candidate_t      mem_d [DEPTH];
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   wr_idx;
  logic            valid_q;
  logic            do_pop, do_push, full;

  // Shift on pop, write at the first free slot, track occupancy.
  always_comb begin
    mem_d   = mem_q;
    cnt_d   = cnt_q;
    do_pop  = pop_i && (cnt_q != '0);
    full    = (cnt_q == CW'(DEPTH));
    drop_o  = push_i && full && !do_pop;
    do_push = push_i && !drop_o;
    wr_idx  = do_pop ? (cnt_q - CW'(1)) : cnt_q;
    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
      mem_d[DEPTH-1] = '0;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (do_push && (wr_idx == CW'(i))) mem_d[i] = push_data_i;
    end
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage, occupancy and registered head-valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      cnt_q   <= cnt_d;
      valid_q <= (cnt_d != '0);
    end
  end

  assign valid_o = valid_q;
  assign data_o  = mem_q[0];

endmodule

// File: rtl/sha3_hash_evaluator.sv
// Final-round hash evaluator: tags each sampled Keccak state with a nonce,
// compares lane 0 against a latched target and queues qualifying candidates.
// Optional feature macro: SHA3_EVAL_DROP_COUNT_EN adds the odrops counter.
//
// state | meaning
// IDLE  | after reset, waiting for start; samples ignored
// SCAN  | counting samples, tagging and comparing hashes
// DONE  | requested number of samples seen; samples ignored
module sha3_hash_evaluator
  import sha3_scanner_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,
  parameter int INPUT_BUFFER = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0][63:0] isa,
  input  logic [4:0][63:0] isb,
  input  logic [4:0][63:0] isc,
  input  logic [4:0][63:0] isd,
  input  logic [4:0][63:0] ise,
  input  logic             sample,
  input  logic             start,
  input  logic [31:0]      base_nonce,
  input  logic [31:0]      count,
  input  logic [63:0]      threshold,
  output logic             ocand_valid,
  output logic [31:0]      ocand_nonce,
  output logic [63:0]      ocand_hash,
  input  logic             icand_ready,
  output logic             obusy,
  output logic             odone,
`ifdef SHA3_EVAL_DROP_COUNT_EN
  output logic [15:0]      odrops,
`endif
  output logic             ooverflow
);

  logic [1:0]  state_q, state_d;
  nonce_t      nonce_q, nonce_d;
  logic [31:0] remain_q, remain_d;
  logic [63:0] thr_q, thr_d;
  logic        ovf_q;
  logic        start_acc, sample_acc, qualify;
  logic        push, fifo_drop;
  candidate_t  push_data, head;

  assign start_acc  = start && (state_q != ST_SCAN);
  assign sample_acc = sample && (state_q == ST_SCAN);
  assign qualify    = hash_qualifies(isa[0], thr_q);

  // Scan control: remaining-sample down-counter reaching one ends the scan.
  always_comb begin
    state_d  = state_q;
    nonce_d  = nonce_q;
    remain_d = remain_q;
    thr_d    = thr_q;
    if (start_acc) begin
      nonce_d  = base_nonce;
      remain_d = count;
      thr_d    = threshold;
      state_d  = (count == '0) ? ST_DONE : ST_SCAN;
    end else if (sample_acc) begin
      nonce_d  = nonce_q + 32'd1;
      remain_d = remain_q - 32'd1;
      if (remain_q == 32'd1) state_d = ST_DONE;
    end
  end

  // Scan state registers; start coinciding with rst loses to rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      nonce_q  <= '0;
      remain_q <= '0;
      thr_q    <= '0;
    end else begin
      state_q  <= state_d;
      nonce_q  <= nonce_d;
      remain_q <= remain_d;
      thr_q    <= thr_d;
    end
  end

  generate
    if (INPUT_BUFFER != 0) begin : g_cmp_reg
      logic       cmp_valid_q;
      candidate_t cmp_cand_q;
      // Compare stage register; drains independently of the FSM state.
      always_ff @(posedge clk) begin
        if (rst) begin
          cmp_valid_q <= 1'b0;
          cmp_cand_q  <= '0;
        end else begin
          cmp_valid_q <= sample_acc && qualify;
          cmp_cand_q  <= '{nonce: nonce_q, hash: isa[0]};
        end
      end
      assign push      = cmp_valid_q;
      assign push_data = cmp_cand_q;
    end else begin : g_cmp_comb
      assign push      = sample_acc && qualify;
      assign push_data = '{nonce: nonce_q, hash: isa[0]};
    end
  endgenerate

  sha3_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (icand_ready),
    .valid_o     (ocand_valid),
    .data_o      (head),
    .drop_o      (fifo_drop)
  );

  // Sticky overflow: cleared by an accepted start, a same-cycle drop still sets it.
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= (ovf_q && !start_acc) || fifo_drop;
  end

`ifdef SHA3_EVAL_DROP_COUNT_EN
  logic [15:0] drops_q;
  // Saturating drop counter, restarted by an accepted start.
  always_ff @(posedge clk) begin
    if (rst)                                 drops_q <= '0;
    else if (start_acc)                      drops_q <= fifo_drop ? 16'd1 : 16'd0;
    else if (fifo_drop && drops_q != 16'hFFFF) drops_q <= drops_q + 16'd1;
  end
  assign odrops = drops_q;
`endif

  assign ocand_nonce = head.nonce;
  assign ocand_hash  = head.hash;
  assign obusy       = (state_q == ST_SCAN);
  assign odone       = (state_q == ST_DONE);
  assign ooverflow   = ovf_q;

  // Only lane 0 of the first plane feeds the compare.
  logic unused_ok;
  assign unused_ok = ^{isa[4:1], isb, isc, isd, ise};

endmodule

// File: tb/tb_sha3_hash_evaluator.sv
// Scoreboard bench for sha3_hash_evaluator with directed vectors.
module tb_sha3_hash_evaluator;
  import sha3_scanner_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0][63:0] isa, isb, isc, isd, ise;
  logic             sample, start, icand_ready;
  logic [31:0]      base_nonce, count;
  logic [63:0]      threshold;
  logic             ocand_valid, obusy, odone, ooverflow;
  logic [31:0]      ocand_nonce;
  logic [63:0]      ocand_hash;
`ifdef SHA3_EVAL_DROP_COUNT_EN
  logic [15:0]      odrops;
`endif

  always #5 clk = ~clk;

  sha3_hash_evaluator dut (
    .clk(clk), .rst(rst),
    .isa(isa), .isb(isb), .isc(isc), .isd(isd), .ise(ise),
    .sample(sample), .start(start),
    .base_nonce(base_nonce), .count(count), .threshold(threshold),
    .ocand_valid(ocand_valid), .ocand_nonce(ocand_nonce), .ocand_hash(ocand_hash),
    .icand_ready(icand_ready),
    .obusy(obusy), .odone(odone),
`ifdef SHA3_EVAL_DROP_COUNT_EN
    .odrops(odrops),
`endif
    .ooverflow(ooverflow)
  );

  candidate_t sb[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic do_start(input logic [31:0] b, input logic [31:0] c, input logic [63:0] t);
    base_nonce = b;
    count      = c;
    threshold  = t;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic do_sample(input logic [63:0] h);
    isa[0] = h;
    sample = 1'b1;
    step();
    sample = 1'b0;
  endtask

  task automatic expect_cand(input logic [31:0] n, input logic [63:0] h);
    candidate_t c;
    c.nonce = n;
    c.hash  = h;
    sb.push_back(c);
  endtask

  // Monitor: compares popped candidates against the scoreboard and checks
  // that a stalled head holds its value.
  logic        hold_pend = 1'b0;
  logic [31:0] held_nonce;
  logic [63:0] held_hash;
  always @(negedge clk) begin
    if (!rst) begin
      if (hold_pend && ocand_valid) begin
        chk("hold_nonce", 64'(ocand_nonce), 64'(held_nonce));
        chk("hold_hash", ocand_hash, held_hash);
      end
      hold_pend  = ocand_valid && !icand_ready;
      held_nonce = ocand_nonce;
      held_hash  = ocand_hash;
      if (ocand_valid && icand_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_cand_nonce", 64'(ocand_nonce), 64'hDEAD_0000_0000_0000);
        end else begin
          candidate_t e;
          e = sb.pop_front();
          chk("cand_nonce", 64'(ocand_nonce), 64'(e.nonce));
          chk("cand_hash", ocand_hash, e.hash);
        end
      end
    end else begin
      hold_pend = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sample = 1'b0; start = 1'b0; icand_ready = 1'b1;
    base_nonce = '0; count = '0; threshold = '0;
    isa = '0;
    isb = {5{64'hBBBB_0000_1111_2222}};
    isc = {5{64'hCCCC_3333_4444_5555}};
    isd = {5{64'hDDDD_6666_7777_8888}};
    ise = {5{64'hEEEE_9999_AAAA_BBBB}};
    idle(2);
    chk("rst_valid", 64'(ocand_valid), 64'd0);
    chk("rst_nonce", 64'(ocand_nonce), 64'd0);
    chk("rst_hash", ocand_hash, 64'd0);
    chk("rst_busy", 64'(obusy), 64'd0);
    chk("rst_done", 64'(odone), 64'd0);
    chk("rst_ovf", 64'(ooverflow), 64'd0);
    rst = 1'b0;
    step();

    // Basic scan: only 0x05 and 0x10 are at or below 0x10.
    do_start(32'd100, 32'd4, 64'h10);
    chk("t1_busy", 64'(obusy), 64'd1);
    expect_cand(32'd101, 64'h05);
    expect_cand(32'd102, 64'h10);
    do_sample(64'h20);
    do_sample(64'h05);
    do_sample(64'h10);
    chk("t1_done_early", 64'(odone), 64'd0);
    do_sample(64'h11);
    chk("t1_done", 64'(odone), 64'd1);
    chk("t1_busy_end", 64'(obusy), 64'd0);
    idle(6);
    chk("t1_sb_empty", 64'(sb.size()), 64'd0);

    // Overflow: six qualifying hashes into a stalled depth-4 FIFO.
    icand_ready = 1'b0;
    do_start(32'd200, 32'd6, 64'hFF);
    for (int i = 1; i <= 6; i++) do_sample(64'(i));
    idle(3);
    chk("t2_ovf", 64'(ooverflow), 64'd1);
    chk("t2_valid", 64'(ocand_valid), 64'd1);
    chk("t2_head_nonce", 64'(ocand_nonce), 64'd200);
`ifdef SHA3_EVAL_DROP_COUNT_EN
    chk("t2_drops", 64'(odrops), 64'd2);
`endif
    expect_cand(32'd200, 64'd1);
    expect_cand(32'd201, 64'd2);
    expect_cand(32'd202, 64'd3);
    expect_cand(32'd203, 64'd4);
    icand_ready = 1'b1;
    idle(8);
    chk("t2_sb_empty", 64'(sb.size()), 64'd0);
    chk("t2_drained", 64'(ocand_valid), 64'd0);

    // Nonce wrap; start also clears overflow.
    do_start(32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t3_ovf_clr", 64'(ooverflow), 64'd0);
`ifdef SHA3_EVAL_DROP_COUNT_EN
    chk("t3_drops_clr", 64'(odrops), 64'd0);
`endif
    expect_cand(32'hFFFF_FFFE, 64'h7);
    expect_cand(32'hFFFF_FFFF, 64'h8);
    expect_cand(32'h0000_0000, 64'h9);
    do_sample(64'h7);
    do_sample(64'h8);
    do_sample(64'h9);
    idle(6);
    chk("t3_sb_empty", 64'(sb.size()), 64'd0);

    // Full FIFO with a pop coinciding with the fifth push.
    icand_ready = 1'b0;
    do_start(32'd300, 32'd5, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int i = 0; i < 5; i++) expect_cand(32'd300 + 32'(i), 64'h31 + 64'(i));
    for (int i = 0; i < 5; i++) do_sample(64'h31 + 64'(i));
    icand_ready = 1'b1;
    step();
    icand_ready = 1'b0;
    step();
    chk("t4_ovf", 64'(ooverflow), 64'd0);
    chk("t4_head_nonce", 64'(ocand_nonce), 64'd301);
`ifdef SHA3_EVAL_DROP_COUNT_EN
    chk("t4_drops", 64'(odrops), 64'd0);
`endif
    icand_ready = 1'b1;
    idle(8);
    chk("t4_sb_empty", 64'(sb.size()), 64'd0);

    // count = 0: done right after start, samples ignored in DONE.
    do_start(32'd400, 32'd0, 64'd0);
    chk("t5_done", 64'(odone), 64'd1);
    chk("t5_busy", 64'(obusy), 64'd0);
    do_sample(64'd0);
    do_sample(64'd0);
    idle(4);

    // Start while scanning is ignored.
    do_start(32'd500, 32'd3, 64'hFFFF_FFFF_FFFF_FFFF);
    expect_cand(32'd500, 64'hA1);
    expect_cand(32'd501, 64'hA2);
    expect_cand(32'd502, 64'hA3);
    do_sample(64'hA1);
    do_start(32'd900, 32'd1, 64'd0);
    chk("t5_busy_after_restart", 64'(obusy), 64'd1);
    do_sample(64'hA2);
    chk("t5_still_busy", 64'(obusy), 64'd1);
    do_sample(64'hA3);
    chk("t5_done_after3", 64'(odone), 64'd1);
    idle(6);
    chk("t5_sb_empty", 64'(sb.size()), 64'd0);

    // Reset mid-scan with two entries queued; start in the reset cycle ignored.
    icand_ready = 1'b0;
    do_start(32'd600, 32'd5, 64'hFFFF_FFFF_FFFF_FFFF);
    do_sample(64'h61);
    do_sample(64'h62);
    idle(2);
    chk("t6_queued", 64'(ocand_valid), 64'd1);
    rst = 1'b1;
    start = 1'b1;
    base_nonce = 32'd700;
    count = 32'd2;
    step();
    rst = 1'b0;
    start = 1'b0;
    chk("t6_valid", 64'(ocand_valid), 64'd0);
    chk("t6_busy", 64'(obusy), 64'd0);
    chk("t6_done", 64'(odone), 64'd0);
    chk("t6_ovf", 64'(ooverflow), 64'd0);
    chk("t6_nonce", 64'(ocand_nonce), 64'd0);
    step();
    chk("t6_idle_busy", 64'(obusy), 64'd0);
    chk("t6_idle_done", 64'(odone), 64'd0);
    icand_ready = 1'b1;
    idle(3);
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
